// File: rtl/mvm_param_if.sv
// Handshake and data bundle between a matrix-vector engine and its driver.
// The master side issues start/x/weights and accepts results; the slave side is the engine.
interface mvm_param_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int X_W    = 4,
  parameter int W_W    = 4,
  parameter int ACC_W  = 16
);
  logic                      i_start_pmvm;
  logic                      i_mode_pmvm;
  logic [N_COLS*X_W-1:0]     i_x_bn;
  logic                      i_w_valid;
  logic [W_W-1:0]            i_w_pmvm;
  logic                      o_w_ready;
  logic                      o_ismvm;
  logic                      o_valid;
  logic                      i_ready;
  logic [N_ROWS*ACC_W-1:0]   o_wx_result;
  logic [N_ROWS-1:0]         o_sat;

  modport master (
    output i_start_pmvm, i_mode_pmvm, i_x_bn, i_w_valid, i_w_pmvm, i_ready,
    input  o_w_ready, o_ismvm, o_valid, o_wx_result, o_sat
  );

  modport slave (
    input  i_start_pmvm, i_mode_pmvm, i_x_bn, i_w_valid, i_w_pmvm, i_ready,
    output o_w_ready, o_ismvm, o_valid, o_wx_result, o_sat
  );
endinterface

// File: rtl/mvm_param.sv
// Streaming matrix-vector multiply: one saturating MAC per accepted weight beat,
// signed-integer or binarised XNOR (+1/-1) products, results held until accepted.
module mvm_param #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int X_W    = 4,
  parameter int W_W    = 4,
  parameter int ACC_W  = 16
) (
  input  logic         i_clk_pmvm,
  input  logic         i_rst_pmvm,
  mvm_param_if.slave   bus
);

  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int P_W   = X_W + W_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]                state_reg;
  logic [N_COLS*X_W-1:0]     x_reg;
  logic                      mode_reg;
  logic [ROW_W-1:0]          row_reg;
  logic [COL_W-1:0]          col_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [ACC_W-1:0]   y_reg [N_ROWS];
  logic [N_ROWS-1:0]         sat_reg;

  logic signed [X_W-1:0]     x_elem [N_COLS];
  logic signed [X_W-1:0]     x_sel;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   p_ext;
  logic signed [ACC_W:0]     sum;
  logic                      ovf;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      beat;
  logic                      start_ok;
  logic                      last_col;
  logic                      last_row;

  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_xsplit
      assign x_elem[gi] = $signed(x_reg[gi*X_W +: X_W]);
    end
  endgenerate

  assign x_sel    = x_elem[col_reg];
  assign prod     = x_sel * $signed(bus.i_w_pmvm);
  assign beat     = (state_reg == S_RUN) && bus.i_w_valid;
  assign start_ok = (state_reg == S_IDLE) && bus.i_start_pmvm;
  assign last_col = (col_reg == COL_W'(N_COLS - 1));
  assign last_row = (row_reg == ROW_W'(N_ROWS - 1));

  always_comb begin
    p_ext = '0;
    if (mode_reg) begin
      // XNOR of the low bits maps to +1 on agreement, -1 otherwise
      p_ext = (x_sel[0] == bus.i_w_pmvm[0]) ? ACC_W'(1) : '1;
    end else begin
      p_ext = ACC_W'(prod);
    end
  end

  // One guard bit: overflow shows as disagreement between the top two sum bits
  assign sum = {acc_reg[ACC_W-1], acc_reg} + {p_ext[ACC_W-1], p_ext};
  assign ovf = sum[ACC_W] != sum[ACC_W-1];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (ovf) begin
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge i_clk_pmvm) begin
    if (i_rst_pmvm) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      mode_reg  <= 1'b0;
      row_reg   <= '0;
      col_reg   <= '0;
      acc_reg   <= '0;
      sat_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.i_start_pmvm) begin
            state_reg <= S_RUN;
            x_reg     <= bus.i_x_bn;
            mode_reg  <= bus.i_mode_pmvm;
            row_reg   <= '0;
            col_reg   <= '0;
            acc_reg   <= '0;
            sat_reg   <= '0;
          end
        end
        S_RUN: begin
          if (beat) begin
            if (ovf) begin
              sat_reg[row_reg] <= 1'b1;
            end
            if (last_col) begin
              acc_reg <= '0;
              col_reg <= '0;
              if (last_row) begin
                state_reg <= S_DONE;
                row_reg   <= '0;
              end else begin
                row_reg <= row_reg + ROW_W'(1);
              end
            end else begin
              acc_reg <= acc_next;
              col_reg <= col_reg + COL_W'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Each row's result register captures the final accumulation of its row
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_rows
      always_ff @(posedge i_clk_pmvm) begin
        if (i_rst_pmvm) begin
          y_reg[gi] <= '0;
        end else if (start_ok) begin
          y_reg[gi] <= '0;
        end else if (beat && last_col && (row_reg == ROW_W'(gi))) begin
          y_reg[gi] <= acc_next;
        end
      end
      assign bus.o_wx_result[gi*ACC_W +: ACC_W] = y_reg[gi];
    end
  endgenerate

  assign bus.o_w_ready = (state_reg == S_RUN);
  assign bus.o_ismvm   = (state_reg != S_IDLE);
  assign bus.o_valid   = (state_reg == S_DONE);
  assign bus.o_sat     = sat_reg;

endmodule

// File: tb/tb_mvm_param.sv
// Randomised and directed bench for mvm_param: a queue of expected results from an
// arithmetic reference model, drained by monitors on each accepted result handshake.
module tb_mvm_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] y;
    logic [3:0]  sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_s[$];

  mvm_param_if #(.ACC_W(16)) bus_a ();
  mvm_param_if #(.ACC_W(8))  bus_s ();

  mvm_param #(.ACC_W(16)) dut_a (.i_clk_pmvm(clk), .i_rst_pmvm(rst), .bus(bus_a));
  mvm_param #(.ACC_W(8))  dut_s (.i_clk_pmvm(clk), .i_rst_pmvm(rst), .bus(bus_s));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // y[r] = sum_c W[r][c]*x[c], clipped to the accumulator range after every term
  function automatic exp_t model(input int xs[4], input int ws[16], input bit mode, input int accw);
    exp_t   e;
    longint mx, mn, mask, acc, p;
    mx   = (longint'(1) << (accw - 1)) - 1;
    mn   = -(longint'(1) << (accw - 1));
    mask = (longint'(1) << accw) - 1;
    e.y   = '0;
    e.sat = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) begin
        if (mode) p = ((xs[c] & 1) == (ws[r*4+c] & 1)) ? 1 : -1;
        else      p = longint'(xs[c]) * longint'(ws[r*4+c]);
        acc = acc + p;
        if (acc > mx) begin acc = mx; e.sat[r] = 1'b1; end
        else if (acc < mn) begin acc = mn; e.sat[r] = 1'b1; end
      end
      e.y = e.y | 64'((acc & mask) << (r * accw));
    end
    return e;
  endfunction

  function automatic logic [15:0] pack_x(input int xs[4]);
    logic [15:0] v;
    for (int c = 0; c < 4; c++) v[c*4 +: 4] = 4'(xs[c]);
    return v;
  endfunction

  function automatic int rnd4();
    int v;
    v = int'($urandom_range(0, 15));
    return (v > 7) ? v - 16 : v;
  endfunction

  // thr: 0 back-to-back, 1 alternating valid, 2 random bubbles
  task automatic run_a(input int xs[4], input int ws[16], input bit mode, input int thr,
                       input int hold, input int abort_at, input bit poke);
    int idx, cyc;
    bit took, poked;
    q_a.push_back(model(xs, ws, mode, 16));
    @(posedge clk); #1;
    bus_a.i_start_pmvm = 1'b1;
    bus_a.i_mode_pmvm  = mode;
    bus_a.i_x_bn       = pack_x(xs);
    bus_a.i_ready      = (hold == 0);
    @(posedge clk); #1;
    bus_a.i_start_pmvm = 1'b0;
    bus_a.i_x_bn       = 16'($urandom);
    bus_a.i_mode_pmvm  = 1'($urandom);
    chk("busy_after_start", 64'(bus_a.o_ismvm), 64'd1);
    idx = 0; cyc = 0; poked = 0;
    while (idx < 16) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        bus_a.i_w_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid",  64'(bus_a.o_valid),   64'd0);
        chk("abort_busy",   64'(bus_a.o_ismvm),   64'd0);
        chk("abort_wready", 64'(bus_a.o_w_ready), 64'd0);
        chk("abort_result", 64'(bus_a.o_wx_result), 64'd0);
        chk("abort_sat",    64'(bus_a.o_sat),     64'd0);
        void'(q_a.pop_back());
        return;
      end
      case (thr)
        0:       bus_a.i_w_valid = 1'b1;
        1:       bus_a.i_w_valid = (cyc % 2 == 0);
        default: bus_a.i_w_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus_a.i_w_pmvm = bus_a.i_w_valid ? 4'(ws[idx]) : 4'($urandom);
      if (poke && idx == 8 && !poked) begin
        bus_a.i_start_pmvm = 1'b1;
        bus_a.i_x_bn       = 16'($urandom);
        poked = 1;
      end
      took = bus_a.i_w_valid && bus_a.o_w_ready;
      @(posedge clk); #1;
      bus_a.i_start_pmvm = 1'b0;
      if (took) idx++;
      cyc++;
      if (cyc > 200) begin
        chk("beat_timeout", 64'(idx), 64'd16);
        break;
      end
    end
    bus_a.i_w_valid = 1'b0;
    chk("latency_valid", 64'(bus_a.o_valid),   64'd1);
    chk("wready_low",    64'(bus_a.o_w_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    bus_a.i_ready = 1'b1;
    cyc = 0;
    while (bus_a.o_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("valid_cleared", 64'(bus_a.o_valid), 64'd0);
    chk("busy_cleared",  64'(bus_a.o_ismvm), 64'd0);
  endtask

  task automatic run_s(input int xs[4], input int ws[16], input bit mode);
    int idx, cyc;
    q_s.push_back(model(xs, ws, mode, 8));
    @(posedge clk); #1;
    bus_s.i_start_pmvm = 1'b1;
    bus_s.i_mode_pmvm  = mode;
    bus_s.i_x_bn       = pack_x(xs);
    bus_s.i_ready      = 1'b1;
    @(posedge clk); #1;
    bus_s.i_start_pmvm = 1'b0;
    bus_s.i_x_bn       = 16'($urandom);
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 100) begin
      bus_s.i_w_valid = 1'b1;
      bus_s.i_w_pmvm  = 4'(ws[idx]);
      @(posedge clk); #1;
      idx++; cyc++;
    end
    bus_s.i_w_valid = 1'b0;
    chk("s_latency_valid", 64'(bus_s.o_valid), 64'd1);
    cyc = 0;
    while (bus_s.o_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("s_valid_cleared", 64'(bus_s.o_valid), 64'd0);
  endtask

  // Result monitors: compare on handshake; while held, compare against the pending entry
  initial forever begin
    @(negedge clk);
    if (!rst && bus_a.o_valid) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_valid", 64'd1, 64'd0);
      end else if (bus_a.i_ready) begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_result", 64'(bus_a.o_wx_result), e.y);
        chk("a_sat",    64'(bus_a.o_sat),       64'(e.sat));
        $display("job A y=%h sat=%b", bus_a.o_wx_result, bus_a.o_sat);
      end else begin
        chk("a_hold_result", 64'(bus_a.o_wx_result), q_a[0].y);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && bus_s.o_valid) begin
      if (q_s.size() == 0) begin
        chk("s_unexpected_valid", 64'd1, 64'd0);
      end else if (bus_s.i_ready) begin
        exp_t e;
        e = q_s.pop_front();
        chk("s_result", 64'(bus_s.o_wx_result), e.y);
        chk("s_sat",    64'(bus_s.o_sat),       64'(e.sat));
        $display("job S y=%h sat=%b", bus_s.o_wx_result, bus_s.o_sat);
      end
    end
  end

  initial begin
    int xs[4];
    int ws[16];
    rst = 1'b1;
    bus_a.i_start_pmvm = 0; bus_a.i_mode_pmvm = 0; bus_a.i_x_bn = '0;
    bus_a.i_w_valid = 0; bus_a.i_w_pmvm = '0; bus_a.i_ready = 1;
    bus_s.i_start_pmvm = 0; bus_s.i_mode_pmvm = 0; bus_s.i_x_bn = '0;
    bus_s.i_w_valid = 0; bus_s.i_w_pmvm = '0; bus_s.i_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  64'(bus_a.o_valid),     64'd0);
    chk("rst_busy",   64'(bus_a.o_ismvm),     64'd0);
    chk("rst_wready", 64'(bus_a.o_w_ready),   64'd0);
    chk("rst_result", 64'(bus_a.o_wx_result), 64'd0);
    chk("rst_sat",    64'(bus_a.o_sat),       64'd0);
    chk("rst_s_result", 64'(bus_s.o_wx_result), 64'd0);
    rst = 1'b0;

    // x = -8 everywhere, w = -8 everywhere
    xs = '{-8, -8, -8, -8};
    for (int i = 0; i < 16; i++) ws[i] = -8;
    run_a(xs, ws, 1'b0, 0, 0, -1, 1'b0);

    // binarised rows against x bits {1,0,1,0}
    xs = '{1, 0, 1, 0};
    ws = '{1, 0, 1, 0,  0, 1, 0, 1,  1, 1, 1, 1,  1, 0, 1, 0};
    run_a(xs, ws, 1'b1, 0, 0, -1, 1'b0);

    // alternating bubbles, consumer stalls five cycles
    xs = '{-8, -8, -8, -8};
    for (int i = 0; i < 16; i++) ws[i] = -8;
    run_a(xs, ws, 1'b0, 1, 5, -1, 1'b0);

    // reset after six beats, then a clean repeat
    run_a(xs, ws, 1'b0, 0, 0, 6, 1'b0);
    run_a(xs, ws, 1'b0, 0, 0, -1, 1'b0);

    // start pulsed mid-run with a different x
    for (int i = 0; i < 4; i++) xs[i] = rnd4();
    for (int i = 0; i < 16; i++) ws[i] = rnd4();
    run_a(xs, ws, 1'b0, 0, 0, -1, 1'b1);

    // narrow accumulator saturates both ways
    xs = '{7, 7, 7, 7};
    for (int i = 0; i < 16; i++) ws[i] = 7;
    run_s(xs, ws, 1'b0);
    for (int i = 0; i < 16; i++) ws[i] = -7;
    run_s(xs, ws, 1'b0);

    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 4; i++) xs[i] = rnd4();
      for (int i = 0; i < 16; i++) ws[i] = rnd4();
      run_a(xs, ws, 1'($urandom), 2, int'($urandom_range(0, 3)), -1, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) xs[i] = rnd4();
      for (int i = 0; i < 16; i++) ws[i] = rnd4();
      run_s(xs, ws, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("s_queue_drained", 64'(q_s.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
